spi_flash_reader: RTL and testbench
===================================

SPI_FLASH_READER -- requirements
Module: spi_flash_reader

Interface
REQ-001 SHALL have parameter LEN_W, default 10, width of the byte-count input.
REQ-002 SHALL have port clk  input  1  system clock (25 MHz pixel clock domain).
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request pulse, sampled only in IDLE.
REQ-005 SHALL have port addr  input  24  flash byte address, captured on accepted start.
REQ-006 SHALL have port len  input  LEN_W  number of bytes to read, captured on accepted start.
REQ-007 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-008 SHALL have port done  output  1  one-cycle pulse at transaction end.
REQ-009 SHALL have port data_out  output  8  received byte, MSB first on the wire.
REQ-010 SHALL have port data_valid  output  1  data_out holds a valid byte.
REQ-011 SHALL have port data_ready  input  1  consumer accepts the byte when data_valid and data_ready are both high.
REQ-012 SHALL have ports spi_cs_n, spi_sclk, spi_mosi (outputs, 1 each) and spi_miso (input, 1).

Function
REQ-013 SHALL implement SPI mode 0: sclk idles low, each bit is one low clk cycle then one high clk cycle (sclk = clk/2).
REQ-014 SHALL change spi_mosi only while sclk is low, and sample spi_miso on the clk edge that ends the sclk-high cycle.
REQ-015 SHALL have states IDLE -> CMD (8 bits) -> ADDR (24 bits, MSB first) -> [DUMMY] -> DATA -> END -> IDLE.
REQ-016 SHALL accept start only in IDLE when busy is low; start in any other state SHALL be ignored.
REQ-017 SHALL drive spi_cs_n low in the cycle after an accepted start, and drive the first command bit in that same cycle.
REQ-018 SHALL send command 0x03 (READ) in CMD when the fast-read feature is compiled out.
REQ-019 SHALL, when an accepted start has len = 0, leave spi_cs_n high and pulse done in the next cycle.
REQ-020 SHALL assert data_valid in the cycle after the 8th bit of a byte is sampled, and hold data_out stable until the handshake.
REQ-021 SHALL continue clocking the next byte while a byte is pending, and SHALL hold sclk low (stall) if the next byte completes before the pending byte is accepted.
REQ-022 SHALL, with data_ready tied high, hold spi_cs_n low for exactly 64+16*len clk cycles (80+16*len with fast read).
REQ-023 SHALL stop clocking after the last bit of byte len, and SHALL enter END only once that byte is accepted.
REQ-024 SHALL, in END, drive spi_cs_n high and pulse done for one cycle; busy SHALL fall in the same cycle.
REQ-025 SHALL keep spi_cs_n high for at least 2 clk cycles between transactions, with IDLE ignoring start in the first of them.
REQ-026 SHALL count len with LEN_W bits; len = 2^LEN_W-1 SHALL read exactly that many bytes with no wrap.
REQ-027 SHALL let the flash wrap its own address; the block SHALL NOT re-issue a command at the 0xFFFFFF boundary.

Reset
REQ-028 SHALL, on rst_n low at any time including mid-transaction, immediately force spi_cs_n=1, spi_sclk=0, spi_mosi=0, busy=0, done=0, data_valid=0, data_out=0, state=IDLE.
REQ-029 SHALL resume operation only on the first clk edge after rst_n rises, with no partial byte delivered.

Configuration
REQ-030 SHALL compile in fast read when macro SPI_FAST_READ_EN is defined: command 0x0B, followed by DUMMY state of 8 sclk cycles with spi_mosi=0 before DATA.
REQ-031 SHALL, without SPI_FAST_READ_EN, use command 0x03 with no DUMMY state; all other behaviour SHALL be identical.

Verification
REQ-032 addr=0x123456, len=3, ready=1, flash model returns 0xA5,0x3C,0xFF -> mosi bits 0x03,0x12,0x34,0x56; three valid pulses with these bytes; cs_n low 112 cycles; one done pulse.
REQ-033 len=2, data_ready held low for 40 cycles after first valid -> data_out stays 0xA5; sclk stalls low after byte 2; no byte lost; done only after both handshakes.
REQ-034 rst_n pulsed low during ADDR bit 10 -> cs_n high, sclk low, busy 0 asynchronously; a fresh start then yields a correct full transaction.
REQ-035 start with len=0 -> cs_n never falls; done pulses in the next cycle; start during busy -> ignored, captured addr unchanged.
REQ-036 SPI_FAST_READ_EN defined, len=1 -> command 0x0B; 8 dummy sclks; cs_n low 96 cycles; byte correct.

Source files
------------

// File: rtl/spi_flash_reader_if.sv
// spi_flash_reader_if: request and byte-stream bundle of the SPI flash reader.
// master = requester/consumer side, slave = reader block.
interface spi_flash_reader_if #(
  parameter int LEN_W = 10
);
  logic             start;
  logic [23:0]      addr;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             done;
  logic [7:0]       data_out;
  logic             data_valid;
  logic             data_ready;

  modport master (
    output start, addr, len, data_ready,
    input  busy, done, data_out, data_valid
  );

  modport slave (
    input  start, addr, len, data_ready,
    output busy, done, data_out, data_valid
  );
endinterface

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: SPI mode-0 flash READ engine with valid/ready byte output.
// Define SPI_FAST_READ_EN for FAST READ (0x0B plus 8 dummy clocks).
module spi_flash_reader #(
  parameter int LEN_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_flash_reader_if.slave bus,
  output logic              spi_cs_n,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] RD_CMD = 8'h0B;
`else
  localparam logic [7:0] RD_CMD = 8'h03;
`endif

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DUMMY, DATA, END
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      tx_q;
  logic [4:0]       cnt_q;
  logic [LEN_W-1:0] left_q;
  logic [7:0]       rx_q;
  logic             rx_full_q;
  logic             sclk_q;
  logic [7:0]       dout_q;
  logic             dv_q;

  logic       last_bit;
  logic       pop;
  logic       free;
  logic       clk_en;
  logic [7:0] rx_byte;

  assign last_bit = sclk_q && (cnt_q == 5'd0);
  assign pop      = dv_q && bus.data_ready;
  assign free     = !dv_q || bus.data_ready;
  // a completed byte that cannot be handed over stalls sclk low
  assign clk_en   = (left_q != '0) && !rx_full_q;
  assign rx_byte  = {rx_q[6:0], spi_miso};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (bus.start)
          state_d = (bus.len == '0) ? END : CMD;
      CMD:
        if (last_bit) state_d = ADDR;
      ADDR:
        if (last_bit) begin
`ifdef SPI_FAST_READ_EN
          state_d = DUMMY;
`else
          state_d = DATA;
`endif
        end
      DUMMY:
        if (last_bit) state_d = DATA;
      DATA:
        if (left_q == '0 && !rx_full_q && free)
          state_d = END;
      END:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q      <= '0;
      cnt_q     <= '0;
      left_q    <= '0;
      rx_q      <= '0;
      rx_full_q <= 1'b0;
      sclk_q    <= 1'b0;
      dout_q    <= '0;
      dv_q      <= 1'b0;
    end else begin
      if (pop) dv_q <= 1'b0;
      if (rx_full_q && free) begin
        dout_q    <= rx_q;
        dv_q      <= 1'b1;
        rx_full_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          sclk_q <= 1'b0;
          if (bus.start) begin
            tx_q   <= {RD_CMD, bus.addr};
            cnt_q  <= 5'd7;
            left_q <= bus.len;
          end
        end
        CMD, ADDR, DUMMY: begin
          sclk_q <= !sclk_q;
          if (sclk_q) begin
            tx_q  <= {tx_q[30:0], 1'b0};
            cnt_q <= cnt_q - 5'd1;
            if (cnt_q == 5'd0)
              cnt_q <= (state_q == CMD) ? 5'd23 : 5'd7;
          end
        end
        DATA: begin
          sclk_q <= !sclk_q && clk_en;
          if (sclk_q) begin
            rx_q  <= rx_byte;
            cnt_q <= cnt_q - 5'd1;
            if (cnt_q == 5'd0) begin
              cnt_q  <= 5'd7;
              left_q <= left_q - 1'b1;
              if (free) begin
                dout_q <= rx_byte;
                dv_q   <= 1'b1;
              end else begin
                rx_full_q <= 1'b1;
              end
            end
          end
        end
        default:
          sclk_q <= 1'b0;
      endcase
    end
  end

  assign spi_cs_n = !((state_q inside {CMD, ADDR, DUMMY}) ||
                      (state_q == DATA && left_q != '0));
  assign spi_sclk = sclk_q;
  assign spi_mosi = (state_q inside {CMD, ADDR}) && tx_q[31];

  assign bus.busy       = state_q inside {CMD, ADDR, DUMMY, DATA};
  assign bus.done       = (state_q == END);
  assign bus.data_out   = dout_q;
  assign bus.data_valid = dv_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// tb_spi_flash_reader: flash-model bench for spi_flash_reader.
// Vector table, random transactions and hand-written corner sequences.
module tb_spi_flash_reader;
  localparam int LEN_W = 10;
`ifdef SPI_FAST_READ_EN
  localparam int         HDR = 40;
  localparam logic [7:0] RCMD = 8'h0B;
`else
  localparam int         HDR = 32;
  localparam logic [7:0] RCMD = 8'h03;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic spi_cs_n, spi_sclk, spi_mosi;
  logic spi_miso = 1'b0;

  spi_flash_reader_if #(.LEN_W(LEN_W)) bus();

  spi_flash_reader #(.LEN_W(LEN_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .spi_cs_n (spi_cs_n),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // flash model: header bits in on rising sclk, data out on falling sclk
  logic [7:0]  fdata[$];
  logic [31:0] hdr;
  int rise_n = 0, fall_n = 0, cs_falls = 0, fk;
  bit dummy_bad = 0;

  always @(negedge spi_cs_n) begin
    rise_n = 0; fall_n = 0; hdr = '0; cs_falls++;
  end

  always @(posedge spi_sclk) if (!spi_cs_n) begin
    if (rise_n < 32) hdr = {hdr[30:0], spi_mosi};
    else if (rise_n < HDR && spi_mosi) dummy_bad = 1;
    rise_n++;
  end

  always @(negedge spi_sclk) if (!spi_cs_n) begin
    fall_n++;
    if (fall_n >= HDR) begin
      fk = fall_n - HDR;
      spi_miso = (fk / 8 < fdata.size()) ? fdata[fk/8][7 - fk%8] : 1'b0;
    end
  end

  // consumer side and observers
  logic [7:0] got[$];
  int done_n = 0, cs_cnt = 0;
  bit rdy_rand = 0;
  bit rdy_val = 1;

  always @(negedge clk)
    bus.data_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;

  always @(posedge clk) begin
    if (bus.data_valid && bus.data_ready) got.push_back(bus.data_out);
    if (bus.done) done_n++;
    if (!spi_cs_n) cs_cnt++;
  end

  task automatic clear_obs();
    got.delete(); done_n = 0; cs_cnt = 0; cs_falls = 0; dummy_bad = 0;
  endtask

  task automatic wait_done(input string nm);
    int t = 0;
    while (done_n == 0 && t < 40000) begin @(negedge clk); t++; end
    if (done_n == 0) begin
      errors++; checks++;
      $display("FAIL %s timeout actual=no_done required=done", nm);
    end
    @(negedge clk);
  endtask

  task automatic check_bytes(input string nm);
    int bad = 0;
    chk({nm, " count"}, got.size(), fdata.size());
    foreach (got[i])
      if (i < fdata.size() && got[i] !== fdata[i]) bad++;
    chk({nm, " bytes"}, bad, 0);
  endtask

  task automatic run_txn(input string nm, input logic [23:0] a,
                         input int n, input bit rnd, input bit keep,
                         input bit poke);
    int t = 0;
    if (!keep) begin
      fdata.delete();
      for (int i = 0; i < n; i++) fdata.push_back(8'($urandom));
    end
    rdy_rand = rnd; rdy_val = 1;
    clear_obs();
    @(negedge clk);
    bus.start = 1; bus.addr = a; bus.len = LEN_W'(n);
    @(negedge clk);
    bus.start = 0;
    while (done_n == 0 && t < 40000) begin
      @(negedge clk); t++;
      if (poke && t == 10) begin
        bus.start = 1; bus.addr = ~a; bus.len = 5;
      end else bus.start = 0;
    end
    if (done_n == 0) begin
      errors++; checks++;
      $display("FAIL %s timeout actual=no_done required=done", nm);
    end
    @(negedge clk);
    chk({nm, " done"}, done_n, 1);
    chk({nm, " cs_falls"}, cs_falls, (n > 0) ? 1 : 0);
    if (n > 0) chk({nm, " hdr"}, hdr, {RCMD, a});
    if (!rnd) chk({nm, " cs_low"}, cs_cnt, (n > 0) ? 2*HDR + 16*n : 0);
    chk({nm, " dummy"}, dummy_bad, 0);
    chk({nm, " busy"}, bus.busy, 0);
    check_bytes(nm);
    rdy_rand = 0;
  endtask

  typedef struct {
    logic [23:0] addr;
    int          len;
    bit          rnd;
    int          exp_cs;
  } vec_t;

  vec_t vt[6];

  initial begin
    bus.start = 0; bus.addr = '0; bus.len = '0;

    vt[0] = '{24'h000000, 1,    0, 2*HDR + 16};
    vt[1] = '{24'hFFFFFE, 4,    0, 2*HDR + 64};
    vt[2] = '{24'hABCDEF, 2,    0, 2*HDR + 32};
    vt[3] = '{24'h800001, 3,    1, 0};
    vt[4] = '{24'h55AA55, 5,    1, 0};
    vt[5] = '{24'h3FF000, 1023, 0, 2*HDR + 16*1023};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst cs_n", spi_cs_n, 1);
    chk("rst sclk", spi_sclk, 0);
    chk("rst mosi", spi_mosi, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    chk("rst dv", bus.data_valid, 0);
    chk("rst dout", bus.data_out, 0);
    rst_n = 1;
    @(negedge clk);

    // basic read with known flash content
    fdata = '{8'hA5, 8'h3C, 8'hFF};
    run_txn("basic", 24'h123456, 3, 0, 1, 0);
    chk("basic cs112", cs_cnt, (HDR == 32) ? 112 : 128);

    // first cycle after accept
    clear_obs();
    fdata = '{8'h5A};
    @(negedge clk);
    bus.start = 1; bus.addr = 24'h00F00F; bus.len = 1;
    @(posedge clk); #1;
    chk("first cs_n", spi_cs_n, 0);
    chk("first mosi", spi_mosi, RCMD[7]);
    chk("first busy", bus.busy, 1);
    chk("first sclk", spi_sclk, 0);
    @(negedge clk); bus.start = 0;
    begin
      int t = 0;
      while (!bus.done && t < 1000) begin @(negedge clk); t++; end
      chk("end seen", bus.done, 1);
      bus.start = 1; bus.addr = 24'h111111;
      @(negedge clk); bus.start = 0;
      repeat (3) @(negedge clk);
      chk("end ignore busy", bus.busy, 0);
      chk("end ignore cs", spi_cs_n, 1);
      chk("end one done", done_n, 1);
    end

    // len = 0
    clear_obs();
    @(negedge clk);
    bus.start = 1; bus.len = 0;
    @(posedge clk); #1;
    bus.start = 0;
    chk("len0 cs_n", spi_cs_n, 1);
    chk("len0 done", bus.done, 1);
    chk("len0 busy", bus.busy, 0);
    @(posedge clk); #1;
    chk("len0 done1", bus.done, 0);
    chk("len0 nofall", cs_falls, 0);

    // start during busy is ignored
    run_txn("poke", 24'hC0FFEE, 2, 0, 0, 1);

    // vector table
    foreach (vt[i]) begin
      run_txn($sformatf("vec%0d", i), vt[i].addr, vt[i].len,
              vt[i].rnd, 0, 0);
      if (!vt[i].rnd) chk($sformatf("vec%0d tbl_cs", i), cs_cnt, vt[i].exp_cs);
    end

    // random transactions
    for (int i = 0; i < 8; i++)
      run_txn($sformatf("rnd%0d", i), 24'($urandom),
              $urandom_range(0, 6), 1, 0, 0);

    // consumer stall
    begin
      int t = 0, r0, bad = 0;
      fdata = '{8'hA5, 8'h3C};
      clear_obs();
      rdy_val = 0;
      @(negedge clk);
      bus.start = 1; bus.addr = 24'h000100; bus.len = 2;
      @(negedge clk); bus.start = 0;
      while (!bus.data_valid && t < 2000) begin @(negedge clk); t++; end
      chk("stall dv", bus.data_valid, 1);
      r0 = rise_n;
      repeat (40) begin
        @(negedge clk);
        if (!bus.data_valid || bus.data_out !== 8'hA5) bad++;
      end
      chk("stall hold", bad, 0);
      chk("stall rises", rise_n - r0, 8);
      chk("stall sclk", spi_sclk, 0);
      chk("stall nodone", done_n, 0);
      rdy_val = 1;
      wait_done("stall");
      chk("stall done", done_n, 1);
      check_bytes("stall");
    end

    // asynchronous reset during ADDR bit 10
    begin
      int t = 0;
      fdata.delete();
      for (int i = 0; i < 4; i++) fdata.push_back(8'($urandom));
      clear_obs();
      rise_n = 0;
      @(negedge clk);
      bus.start = 1; bus.addr = 24'hDEAD01; bus.len = 4;
      @(negedge clk); bus.start = 0;
      while (rise_n < 19 && t < 1000) begin @(negedge clk); t++; end
      chk("arst reached", rise_n >= 19, 1);
      #3 rst_n = 0;
      #1;
      chk("arst cs_n", spi_cs_n, 1);
      chk("arst sclk", spi_sclk, 0);
      chk("arst busy", bus.busy, 0);
      chk("arst mosi", spi_mosi, 0);
      @(negedge clk); rst_n = 1;
      repeat (4) @(negedge clk);
      chk("arst nobyte", got.size(), 0);
      chk("arst nodone", done_n, 0);
      run_txn("post_rst", 24'h0A0B0C, 4, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
